// File: rtl/vcd_capture.sv
// vcd_capture: value-change capture of CHANNELS monitored buses into a timestamped event FIFO.
// Define VCD_CAPTURE_MARKER_EN to push a marker entry (channel all-ones, value 0) on each accepted dump_off.
module vcd_capture #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] sig_in,
    input  logic                      dump_on,
    input  logic                      dump_off,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W-1:0]           out_ts,
    output logic [$clog2(CHANNELS):0] out_ch,
    output logic [WIDTH-1:0]          out_val,
    output logic                      dumping,
    output logic                      overflow
);
    localparam int IW = $clog2(CHANNELS);
    localparam int CW = IW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_CH  = IW'(CHANNELS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DUMPALL, CAPTURE, PAUSED} state_t;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [CW-1:0]    ch;
        logic [WIDTH-1:0] val;
    } entry_t;

    state_t                         state_q, state_d;
    logic [TS_W-1:0]                ts_q;
    logic [IW-1:0]                  idx_q, idx_d, sel;
    logic [CHANNELS-1:0][WIDTH-1:0] sig, last_q, last_d;
    logic                           ovf_q, ovf_d, dumping_q;
    entry_t                         mem [DEPTH];
    entry_t                         push_e, head;
    logic [AW-1:0]                  wr_q, rd_q;
    logic [AW:0]                    cnt_q;
    logic full, pop, push_req, push, on_acc, off_acc, mark_now, hit;

    assign sig       = sig_in;
    assign on_acc    = dump_on  && (state_q == IDLE    || state_q == PAUSED);
    assign off_acc   = dump_off && (state_q == DUMPALL || state_q == CAPTURE);
    assign full      = (cnt_q == FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    // Full blocks the push even when a pop frees a slot in the same cycle.
    assign push      = push_req && !full;

`ifdef VCD_CAPTURE_MARKER_EN
    // A blocked marker stays pending and takes priority over data until it lands.
    logic mpend_q;
    assign mark_now = mpend_q || off_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mpend_q <= 1'b0;
        else        mpend_q <= mark_now && full;
    end
`else
    assign mark_now = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        push_req = 1'b0;
        push_e   = '0;
        sel      = '0;
        hit      = 1'b0;
        if (on_acc) begin
            state_d = DUMPALL;
            idx_d   = '0;
            ovf_d   = 1'b0;
        end
        if (off_acc) state_d = PAUSED;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (sig[k] != last_q[k]) begin
                sel = IW'(k);
                hit = 1'b1;
            end
        end
        if (mark_now) begin
            push_req = 1'b1;
        end else if (state_d == DUMPALL) begin
            push_req = 1'b1;
            sel      = idx_d;
            if (!full) begin
                if (idx_d == LAST_CH) begin
                    idx_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    idx_d = idx_d + 1'b1;
                end
            end
        end else if (state_d == CAPTURE) begin
            push_req = hit;
        end
        push_e.ts = ts_q;
        if (mark_now) begin
            push_e.ch = '1;
        end else begin
            push_e.ch  = {1'b0, sel};
            push_e.val = sig[sel];
        end
        if (push_req && full) ovf_d = 1'b1;
        if (push && !mark_now) last_d[sel] = sig[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ts_q      <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            ovf_q     <= 1'b0;
            dumping_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_q + 1'b1;
            idx_q     <= idx_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            dumping_q <= (state_d == DUMPALL) || (state_d == CAPTURE);
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q     <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= push_e;
    end

    assign head     = mem[rd_q];
    assign out_ts   = out_valid ? head.ts  : '0;
    assign out_ch   = out_valid ? head.ch  : '0;
    assign out_val  = out_valid ? head.val : '0;
    assign dumping  = dumping_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_vcd_capture.sv
// tb_vcd_capture: random and directed scenarios for vcd_capture, checked against a queue-based model.
module tb_vcd_capture;
    localparam int W = 8, CH = 4, D = 16, TW = 16, CW = 3;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [CH*W-1:0] sig_in = '0;
    logic          dump_on = 1'b0, dump_off = 1'b0, out_ready = 1'b1;
    logic          out_valid, dumping, overflow;
    logic [TW-1:0] out_ts;
    logic [CW-1:0] out_ch;
    logic [W-1:0]  out_val;

    vcd_capture #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .TS_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .dump_on(dump_on), .dump_off(dump_off),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_ch(out_ch),
        .out_val(out_val), .dumping(dumping), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] ts;
        logic [CW-1:0] ch;
        logic [W-1:0]  val;
    } ent_t;

    // Model: mst 0=idle 1=dumping all 2=capturing 3=paused
    ent_t          mq[$], mexp[$], seen[$];
    int            mst, midx;
    logic [W-1:0]  mlast[CH], cur[CH];
    logic          movf, mmark;
    logic [TW-1:0] mts;
    int            total = 0, bad = 0;

    task automatic model_reset();
        mq.delete(); mexp.delete(); seen.delete();
        mst = 0; midx = 0; movf = 1'b0; mmark = 1'b0; mts = '0;
        for (int k = 0; k < CH; k++) mlast[k] = '0;
    endtask

    task automatic model_step(input bit on, input bit off, input bit rdy);
        bit   full, on_acc, off_acc, have, ok, mark;
        int   nst, sel;
        ent_t e;
        full    = (mq.size() == D);
        on_acc  = on  && (mst == 0 || mst == 3);
        off_acc = off && (mst == 1 || mst == 2);
        nst = mst; have = 0; sel = -1; e = '0;
        if (on_acc) begin nst = 1; midx = 0; movf = 1'b0; end
        if (off_acc) nst = 3;
`ifdef VCD_CAPTURE_MARKER_EN
        if (off_acc) mmark = 1'b1;
`endif
        mark = mmark;
        e.ts = mts;
        if (mark) begin
            have = 1; e.ch = '1; e.val = '0;
        end else if (nst == 1) begin
            have = 1; sel = midx;
        end else if (nst == 2) begin
            for (int k = CH - 1; k >= 0; k--) if (cur[k] !== mlast[k]) sel = k;
            have = (sel >= 0);
        end
        if (!mark && have) begin e.ch = CW'(sel); e.val = cur[sel]; end
        ok = have && !full;
        if (have && full) movf = 1'b1;
        if (ok) begin
            if (mark) mmark = 1'b0;
            else begin
                mlast[sel] = cur[sel];
                if (nst == 1) begin
                    if (midx == CH - 1) begin midx = 0; nst = 2; end
                    else midx++;
                end
            end
        end
        if (rdy && mq.size() > 0) mexp.push_back(mq.pop_front());
        if (ok) mq.push_back(e);
        mst = nst;
        mts = mts + 1'b1;
    endtask

    task automatic tick(input bit on, input bit off);
        ent_t e;
        dump_on = on; dump_off = off;
        for (int k = 0; k < CH; k++) sig_in[k*W +: W] = cur[k];
        if (out_valid && out_ready) begin
            e.ts = out_ts; e.ch = out_ch; e.val = out_val;
            seen.push_back(e);
        end
        model_step(on, off, out_ready);
        @(posedge clk); #1;
        dump_on = 1'b0; dump_off = 1'b0;
    endtask

    task automatic run_to(input logic [TW-1:0] t);
        int guard = 0;
        while (mts != t && guard < 70000) begin tick(0, 0); guard++; end
    endtask

    task automatic test_reset();
        for (int k = 0; k < CH; k++) cur[k] = '0;
        model_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (dumping !== 1'b0) begin bad++; $display("FAIL rst_dumping got=%b exp=0", dumping); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        total++; if ({out_ts, out_ch, out_val} !== '0) begin bad++; $display("FAIL rst_head got=%h exp=0", {out_ts, out_ch, out_val}); end
        rst_n = 1'b1;
    endtask

    task automatic test_dumpall();
        cur[0] = 8'd11; cur[1] = 8'd22; cur[2] = 8'd33; cur[3] = 8'd44;
        out_ready = 1'b1;
        run_to(16'd10);
        tick(1, 0);
        repeat (6) tick(0, 0);
        total++; if (seen.size() != 4) begin bad++; $display("FAIL dumpall_count got=%0d exp=4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            total++;
            if (seen[i] !== {16'(10 + i), 3'(i), 8'(11 * (i + 1))}) begin
                bad++; $display("FAIL dumpall_entry%0d got=%h exp=%h", i, seen[i], {16'(10 + i), 3'(i), 8'(11 * (i + 1))});
            end
        end
        total++; if (dumping !== 1'b1) begin bad++; $display("FAIL dumpall_dumping got=%b exp=1", dumping); end
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] v1, v3;
        seen.delete(); mexp.delete();
        run_to(16'd40);
        v1 = cur[1] ^ 8'($urandom_range(1, 255));
        v3 = cur[3] ^ 8'($urandom_range(1, 255));
        cur[1] = v1; cur[3] = v3;
        repeat (5) tick(0, 0);
        total++; if (seen.size() != 2) begin bad++; $display("FAIL same_count got=%0d exp=2", seen.size()); end
        total++; if (seen.size() > 0 && seen[0] !== {16'd40, 3'd1, v1}) begin bad++; $display("FAIL same_first got=%h exp=%h", seen[0], {16'd40, 3'd1, v1}); end
        total++; if (seen.size() > 1 && seen[1] !== {16'd41, 3'd3, v3}) begin bad++; $display("FAIL same_second got=%h exp=%h", seen[1], {16'd41, 3'd3, v3}); end
    endtask

    task automatic test_pause();
        int first;
        seen.delete(); mexp.delete();
        run_to(16'd50);
        tick(0, 1);
        run_to(16'd60);
        cur[0] = cur[0] ^ 8'($urandom_range(1, 255));
        run_to(16'd100);
        total++; if (dumping !== 1'b0) begin bad++; $display("FAIL pause_dumping got=%b exp=0", dumping); end
        tick(1, 0);
        repeat (6) tick(0, 0);
        first = -1;
        foreach (seen[i]) begin
            if (seen[i].ch == 3'd0 && seen[i].ts < 16'd100) begin
                total++; bad++; $display("FAIL pause_early_ch0 got=%h exp=none", seen[i]);
            end
            if (first < 0 && seen[i].ch != 3'h7) first = i;
        end
        total++;
        if (first < 0 || seen[first] !== {16'd100, 3'd0, cur[0]}) begin
            bad++; $display("FAIL pause_redump got=%h exp=%h", (first < 0) ? ent_t'('0) : seen[first], {16'd100, 3'd0, cur[0]});
        end
`ifdef VCD_CAPTURE_MARKER_EN
        total++; if (seen.size() == 0 || seen[0] !== {16'd50, 3'h7, 8'd0}) begin bad++; $display("FAIL pause_marker exp=%h", {16'd50, 3'h7, 8'd0}); end
`endif
        total++; if (seen.size() != mexp.size()) begin bad++; $display("FAIL pause_count got=%0d exp=%0d", seen.size(), mexp.size()); end
        foreach (mexp[i]) if (i < seen.size()) begin
            total++; if (seen[i] !== mexp[i]) begin bad++; $display("FAIL pause_entry%0d got=%h exp=%h", i, seen[i], mexp[i]); end
        end
    endtask

    task automatic test_overflow();
        seen.delete(); mexp.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cur[i % CH] = cur[i % CH] ^ 8'($urandom_range(1, 255));
            tick(0, 0);
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        out_ready = 1'b1;
        repeat (30) tick(0, 0);
        total++; if (seen.size() != mexp.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", seen.size(), mexp.size()); end
        foreach (mexp[i]) if (i < seen.size()) begin
            total++; if (seen[i] !== mexp[i]) begin bad++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, seen[i], mexp[i]); end
        end
        total++; if (seen.size() > 15 && seen[15].ts - seen[0].ts != 16'd15) begin bad++; $display("FAIL ovf_burst got=%0d exp=15", seen[15].ts - seen[0].ts); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        tick(0, 1);
        tick(1, 0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        repeat (8) tick(0, 0);
    endtask

    task automatic test_onoff_reset();
        tick(1, 1);
        total++; if (dumping !== 1'b0) begin bad++; $display("FAIL onoff_dumping got=%b exp=0", dumping); end
        repeat (4) tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL mid_valid got=%b exp=%b", out_valid, mq.size() > 0); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
        total++; if (dumping !== 1'b0) begin bad++; $display("FAIL mid_reset_dumping got=%b exp=0", dumping); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (5) tick(0, 0);
        total++; if (out_valid !== 1'b0 || dumping !== 1'b0) begin bad++; $display("FAIL post_reset got=%b%b exp=00", out_valid, dumping); end
    endtask

    task automatic test_random();
        seen.delete(); mexp.delete();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) begin
                int k;
                k = $urandom_range(CH - 1);
                cur[k] = 8'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            tick($urandom_range(29) == 0, $urandom_range(39) == 0);
            if (c % 50 == 0) begin
                total++; if (overflow !== movf) begin bad++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, overflow, movf); end
                total++; if (dumping !== (mst == 1 || mst == 2)) begin bad++; $display("FAIL rand_dumping c=%0d got=%b exp=%b", c, dumping, mst == 1 || mst == 2); end
            end
        end
        out_ready = 1'b1;
        repeat (40) tick(0, 0);
        total++; if (seen.size() != mexp.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", seen.size(), mexp.size()); end
        foreach (mexp[i]) if (i < seen.size()) begin
            total++; if (seen[i] !== mexp[i]) begin bad++; $display("FAIL rand_entry%0d got=%h exp=%h", i, seen[i], mexp[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] v0, v1;
        out_ready = 1'b1;
        tick(1, 0);
        repeat (40) tick(0, 0);
        seen.delete(); mexp.delete();
        run_to(16'hFFFF);
        v0 = cur[0] ^ 8'($urandom_range(1, 255));
        v1 = cur[1] ^ 8'($urandom_range(1, 255));
        cur[0] = v0; cur[1] = v1;
        repeat (5) tick(0, 0);
        total++; if (seen.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", seen.size()); end
        total++; if (seen.size() > 0 && seen[0] !== {16'hFFFF, 3'd0, v0}) begin bad++; $display("FAIL wrap_first got=%h exp=%h", seen[0], {16'hFFFF, 3'd0, v0}); end
        total++; if (seen.size() > 1 && seen[1] !== {16'h0000, 3'd1, v1}) begin bad++; $display("FAIL wrap_second got=%h exp=%h", seen[1], {16'h0000, 3'd1, v1}); end
    endtask

    initial begin
        test_reset();
        test_dumpall();
        test_same_cycle();
        test_pause();
        test_overflow();
        test_onoff_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vcd_capture.md
VCD_CAPTURE -- requirements
Module: vcd_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per monitored channel.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of monitored channels (2..16).
REQ-003 SHALL have parameter DEPTH, default 16, meaning event FIFO entries (power of two).
REQ-004 SHALL have parameter TS_W, default 16, meaning timestamp width.
REQ-005 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sig_in  input  CHANNELS*WIDTH  monitored values; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port dump_on  input  1  single-cycle pulse that starts or resumes dumping.
REQ-009 SHALL have port dump_off  input  1  single-cycle pulse that pauses dumping.
REQ-010 SHALL have port out_valid  output  1  FIFO head entry valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port out_ts  output  TS_W  timestamp of head entry.
REQ-013 SHALL have port out_ch  output  $clog2(CHANNELS)+1  channel of head entry; all-ones means marker.
REQ-014 SHALL have port out_val  output  WIDTH  value of head entry.
REQ-015 SHALL have port dumping  output  1  high in DUMPALL or CAPTURE.
REQ-016 SHALL have port overflow  output  1  sticky flag: a push was blocked by a full FIFO.

Function
REQ-017 SHALL run a free-running TS_W counter from 0 after reset, incrementing every cycle and wrapping from all-ones to 0.
REQ-018 SHALL implement states IDLE, DUMPALL, CAPTURE, PAUSED; reset enters IDLE.
REQ-019 SHALL move IDLE or PAUSED to DUMPALL on dump_on; ignore dump_on in DUMPALL or CAPTURE.
REQ-020 SHALL move DUMPALL or CAPTURE to PAUSED on dump_off; dump_off wins when dump_on is asserted in the same cycle.
REQ-021 In DUMPALL SHALL push channels 0..CHANNELS-1 in order, one per non-full cycle, with the current value; it SHALL load each channel's last-recorded register; after channel CHANNELS-1 it SHALL enter CAPTURE.
REQ-022 In CAPTURE SHALL each cycle push the lowest-indexed channel whose sig_in differs from its last-recorded value, then update that register; rapid toggles between pushes merge.
REQ-023 Entries SHALL carry the counter value of the push cycle; an input change in cycle n appears on out_valid in cycle n+1 when the FIFO is empty and no lower channel is pending.
REQ-024 SHALL block a push when the FIFO is full, including on a same-cycle pop; a blocked push SHALL set overflow and be retried, and last-recorded SHALL NOT update.
REQ-025 SHALL pop on out_valid && out_ready; out_ts/out_ch/out_val SHALL hold while out_valid && !out_ready.
REQ-026 SHALL keep draining FIFO contents in PAUSED and IDLE; no new pushes occur there except per REQ-031.
REQ-027 SHALL clear overflow on dump_on acceptance.

Reset
REQ-028 SHALL on rst_n low asynchronously clear the state to IDLE, the counter to 0, the FIFO to empty, and last-recorded registers to 0.
REQ-029 SHALL hold out_valid=0, dumping=0, overflow=0, and out_ts/out_ch/out_val=0 during reset.
REQ-030 SHALL discard any in-flight FIFO contents and a partial DUMPALL on reset mid-operation.

Configuration
REQ-031 With VCD_CAPTURE_MARKER_EN defined, an accepted dump_off SHALL push a marker (out_ch all-ones, out_val 0, current timestamp), subject to REQ-024; without it, no marker SHALL be pushed and out_ch MSB SHALL always be 0.

Verification
REQ-032 Reset, dump_on at ts=10 with sig_in ch0..3 = 11,22,33,44 -> entries (10,0,11),(11,1,22),(12,2,33),(13,3,44), then dumping=1 in CAPTURE.
REQ-033 In CAPTURE, ch1 and ch3 change in the same cycle ts=40 -> (40,1,x) then (41,3,y).
REQ-034 dump_off at ts=50, ch0 toggles at ts=60, dump_on at ts=100 -> no ch0 entry before 100, then a full re-dump starting at ts=100; with the macro, marker (50,all-ones,0).
REQ-035 Hold out_ready=0, DEPTH=16, force 20 changes -> exactly 16 entries, overflow=1, remaining changes emitted after out_ready=1, overflow cleared by the next dump_on.
REQ-036 Same-cycle dump_on and dump_off in CAPTURE -> PAUSED; rst_n low mid-DUMPALL -> out_valid=0 immediately, IDLE.
REQ-037 Counter at 0xFFFF with a change pending -> timestamps 0xFFFF then 0x0000 are ordered correctly.
